// File: rtl/const_mult_pkg.sv
// Shared types and default widths for the serial signed constant multiplier.
package const_mult_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int COEF_W_DEF = 8;
   localparam int COEF_N83   = -83;

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready high
   // CALC  | one coefficient bit consumed per clock, acc accumulating
   // DONE  | product presented on out_data, waiting for out_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/const_mult_serial_shift_add_step.sv
// One shift-add step: conditionally adds (or, for the coefficient sign bit,
// subtracts) the shifted multiplicand into the accumulator. Purely combinational.
module shift_add_step #(
   parameter int OUT_W = 24,
   parameter int CNT_W = 3
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [OUT_W-1:0] mcand,
   input  logic [CNT_W-1:0] shamt,
   input  logic             bit_en,
   input  logic             sign_bit,
   output logic [OUT_W-1:0] acc_next
);

   logic [OUT_W-1:0] shifted;

   assign shifted = mcand << shamt;

   // The sign bit of a two's complement coefficient carries negative weight.
   always_comb begin
      acc_next = acc;
      if (bit_en) begin
         if (sign_bit) begin
            acc_next = acc - shifted;
         end else begin
            acc_next = acc + shifted;
         end
      end
   end

endmodule

// File: rtl/const_mult_serial.sv
// Sequential signed multiplier, one coefficient bit per clock (shift-add).
// Fixed latency of COEF_W cycles from accept to out_valid, no operation overlap.
module const_mult_serial
   import const_mult_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int COEF_W = COEF_W_DEF,
   localparam int OUT_W  = DATA_W + COEF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [COEF_W-1:0] in_coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              busy
);

   localparam int CNT_W = $clog2(COEF_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEF_W - 1);

   state_t            state;
   logic [OUT_W-1:0]  mcand;
   logic [COEF_W-1:0] coef;
   logic [OUT_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [OUT_W-1:0]  acc_next;
   logic              last_bit;

   assign last_bit = (cnt == CNT_LAST);

   shift_add_step #(
      .OUT_W (OUT_W),
      .CNT_W (CNT_W)
   ) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .shamt    (cnt),
      .bit_en   (coef[cnt]),
      .sign_bit (last_bit),
      .acc_next (acc_next)
   );

   // Control FSM and datapath registers; all outputs are registered so
   // nothing on in_* reaches out_* combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mcand     <= '0;
         coef      <= '0;
         acc       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mcand    <= {{COEF_W{in_data[DATA_W-1]}}, in_data};
                  coef     <= in_coef;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc <= acc_next;
               if (last_bit) begin
                  // out_data is loaded only here, so it keeps the last
                  // product across the handshake and the next operation.
                  out_data  <= acc_next;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_const_mult_serial.sv
// Directed and random checks of const_mult_serial at default widths and at
// DATA_W=12 / COEF_W=5, with a queue of expected products as scoreboard.
module tb_const_mult_serial;

   localparam int DW  = 16;
   localparam int CW  = 8;
   localparam int OW  = DW + CW;
   localparam int DW2 = 12;
   localparam int CW2 = 5;
   localparam int OW2 = DW2 + CW2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_coef;
   logic [OW-1:0] out_data;

   logic           in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [DW2-1:0] in_data2;
   logic [CW2-1:0] in_coef2;
   logic [OW2-1:0] out_data2;

   int checks = 0;
   int errors = 0;
   logic [OW-1:0]  exp_q[$];
   logic [OW2-1:0] exp_q2[$];

   const_mult_serial #(.DATA_W(DW), .COEF_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_coef(in_coef),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   const_mult_serial #(.DATA_W(DW2), .COEF_W(CW2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_coef(in_coef2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the default-width instance. Time is always 1 ns
   // after a rising edge on entry and exit.
   task automatic op(input logic [DW-1:0] d, input logic [CW-1:0] c, input int hold,
                     input bit chk_hold, input bit busy_drive,
                     input logic [DW-1:0] d2, input logic [CW-1:0] c2);
      int n;
      int lat;
      bit accepted;
      logic signed [OW-1:0] sd, sc;
      logic [OW-1:0] e, held;
      in_valid = 1'b1;
      in_data  = d;
      in_coef  = c;
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < 40) begin
         accepted = in_ready;
         tick();
         n++;
      end
      chk("accept", 64'(accepted), 64'd1);
      if (!accepted) begin
         in_valid = 1'b0;
         return;
      end
      sd = $signed(d);
      sc = $signed(c);
      e  = sd * sc;
      exp_q.push_back(e);
      if (busy_drive) begin
         in_data = d2;
         in_coef = c2;
      end else begin
         in_valid = 1'b0;
         in_data  = DW'($urandom);
         in_coef  = CW'($urandom);
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (busy_drive) chk("busy_in_ready", 64'(in_ready), 64'd0);
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'(CW));
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (chk_hold) begin
            chk("hold_data", 64'(out_data), 64'(held));
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
         end
      end
      out_ready = 1'b1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         chk("product", 64'(out_data), 64'(exp_q.pop_front()));
      end
      tick();
      out_ready = 1'b0;
      chk("post_valid", 64'(out_valid), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
      chk("post_keep", 64'(out_data), 64'(e));
   endtask

   task automatic op2(input logic [DW2-1:0] d, input logic [CW2-1:0] c, input int hold);
      int n;
      int lat;
      bit accepted;
      logic signed [OW2-1:0] sd, sc;
      in_valid2 = 1'b1;
      in_data2  = d;
      in_coef2  = c;
      accepted  = 1'b0;
      n = 0;
      while (!accepted && n < 40) begin
         accepted = in_ready2;
         tick();
         n++;
      end
      chk("accept2", 64'(accepted), 64'd1);
      in_valid2 = 1'b0;
      if (!accepted) return;
      sd = $signed(d);
      sc = $signed(c);
      exp_q2.push_back(sd * sc);
      lat = 0;
      while (!out_valid2 && lat < 40) begin
         tick();
         lat++;
      end
      chk("latency2", 64'(lat), 64'(CW2));
      repeat (hold) tick();
      out_ready2 = 1'b1;
      if (exp_q2.size() == 0) begin
         chk("scoreboard2_empty", 64'd1, 64'd0);
      end else begin
         chk("product2", 64'(out_data2), 64'(exp_q2.pop_front()));
      end
      tick();
      out_ready2 = 1'b0;
      chk("post_valid2", 64'(out_valid2), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_coef = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0; in_coef2 = '0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // legacy x(-83)
      op(16'd1, 8'hAD, 0, 1'b0, 1'b0, '0, '0);
      chk("legacy_1", 64'(out_data), 64'h0FFFFAD);
      op(16'd100, 8'hAD, 0, 1'b0, 1'b0, '0, '0);
      chk("legacy_100", 64'(out_data), 64'h0FFDF94);

      // abort mid-CALC
      in_valid = 1'b1; in_data = 16'd1234; in_coef = 8'hFB;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      op(16'hFFF6, 8'd7, 0, 1'b0, 1'b0, '0, '0);
      chk("after_abort", 64'(out_data), 64'h0FFFFBA);

      // corners
      op(16'h8000, 8'h80, 0, 1'b0, 1'b0, '0, '0);
      chk("min_min", 64'(out_data), 64'h0400000);
      op(16'h7FFF, 8'h7F, 0, 1'b0, 1'b0, '0, '0);
      chk("max_max", 64'(out_data), 64'h03F7F81);
      op(16'h8000, 8'h7F, 0, 1'b0, 1'b0, '0, '0);
      chk("min_max", 64'(out_data), 64'h0C08000);
      op(16'd12345, 8'h00, 0, 1'b0, 1'b0, '0, '0);
      chk("coef_zero", 64'(out_data), 64'd0);
      op(16'd0, 8'hAD, 0, 1'b0, 1'b0, '0, '0);
      chk("data_zero", 64'(out_data), 64'd0);

      // backpressure in DONE
      op(16'd3000, 8'hC3, 5, 1'b1, 1'b0, '0, '0);

      // in_valid held with new data while busy; second op must see the new pair
      op(16'd77, 8'd9, 2, 1'b1, 1'b1, 16'hFF00, 8'h85);
      chk("busy_ignored", 64'(out_data), 64'd693);
      op(16'hFF00, 8'h85, 0, 1'b0, 1'b0, '0, '0);

      // random traffic, default widths
      for (int i = 0; i < 1500; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         op(DW'($urandom), CW'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, '0);
      end

      // narrow instance: corners then random
      op2(12'h800, 5'h10, 0);
      chk("n_min_min", 64'(out_data2), 64'h08000);
      op2(12'h7FF, 5'h0F, 1);
      chk("n_max_max", 64'(out_data2), 64'h077F1);
      for (int i = 0; i < 800; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         op2(DW2'($urandom), CW2'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
